// File: rtl/sum_accum.sv
// Accumulates BEATS adder results ({c_out,sum}) into an ACC_W-bit total and
// hands the total plus a sticky overflow flag downstream over valid/ready.
module sum_accum #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 8,
  parameter int BEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DONE  = 1'b1;

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [SUM_W-1:0] sum;
  logic             accept;
  logic             consume;

  // One extra bit above the accumulator captures the carry-out used for ovf.
  function automatic logic [SUM_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [IN_W-1:0]  d);
    return {1'b0, a} + SUM_W'(d);
  endfunction

  assign sum     = acc_add(acc, in_data);
  assign accept  = in_valid && (state == ACCUM);
  assign consume = out_ready && (state == DONE);

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (accept) begin
      acc <= sum[ACC_W-1:0];
      cnt <= cnt + 1'b1;
      if (sum[ACC_W]) ovf <= 1'b1;
      if (cnt == LAST_CNT) state <= DONE;
    end else if (consume) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum: three configurations (defaults, ACC_W=6, BEATS=1)
// checked every cycle against a beat-total model plus literal expectations.
module tb_sum_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv[3];
  logic [4:0] id[3];
  logic       ordy[3];
  logic       irdy[3];
  logic       ov[3];
  logic       ovf[3];
  logic [7:0] acc0, acc2;
  logic [5:0] acc1;
  int         oacc[3];

  sum_accum u_def (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_acc(acc0), .out_ovf(ovf[0]));

  sum_accum #(.ACC_W(6)) u_ovf (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_acc(acc1), .out_ovf(ovf[1]));

  sum_accum #(.BEATS(1)) u_b1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(id[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_acc(acc2), .out_ovf(ovf[2]));

  always_comb begin
    oacc[0] = int'(acc0);
    oacc[1] = int'(acc1);
    oacc[2] = int'(acc2);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Model: integer sum of accepted beats; the result is that sum mod 2^ACC_W,
  // overflow is whether the plain sum reached 2^ACC_W.
  int  acc_w[3] = '{8, 6, 8};
  int  beats[3] = '{4, 4, 1};
  int  m_sum[3];
  int  m_n[3];
  bit  m_done[3];
  bit  chk_en = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_sum[k] = 0; m_n[k] = 0; m_done[k] = 1'b0;
      end else if (!m_done[k] && iv[k]) begin
        m_sum[k] += int'(id[k]);
        m_n[k]++;
        if (m_n[k] == beats[k]) m_done[k] = 1'b1;
      end else if (m_done[k] && ordy[k]) begin
        m_sum[k] = 0; m_n[k] = 0; m_done[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("model_in_ready%0d", k), int'(irdy[k]), int'(!m_done[k]));
        check($sformatf("model_out_valid%0d", k), int'(ov[k]), int'(m_done[k]));
        if (m_done[k]) begin
          check($sformatf("model_out_acc%0d", k), oacc[k], m_sum[k] % (1 << acc_w[k]));
          check($sformatf("model_out_ovf%0d", k), int'(ovf[k]),
                int'(m_sum[k] >= (1 << acc_w[k])));
        end
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; id[k] = '0; ordy[k] = 1'b0;
    end
  endtask

  task automatic lit(input string name, input int k, input int vld, input int rdy,
                     input int accv, input int ovfv);
    check({name, "_out_valid"}, int'(ov[k]), vld);
    check({name, "_in_ready"}, int'(irdy[k]), rdy);
    check({name, "_out_acc"}, oacc[k], accv);
    check({name, "_out_ovf"}, int'(ovf[k]), ovfv);
  endtask

  logic [4:0] basic_beats[4] = '{5'b01110, 5'b10100, 5'b10110, 5'b11111};
  bit         gap_pat[7]     = '{1, 0, 0, 1, 0, 1, 1};

  initial begin
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) lit($sformatf("reset%0d", k), k, 0, 1, 0, 0);
    chk_en = 1'b1;

    // Basic accumulation, defaults
    ordy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; id[0] = basic_beats[i];
      tick();
      if (i < 3) check("basic_no_early_valid", int'(ov[0]), 0);
    end
    iv[0] = 1'b0;
    lit("basic", 0, 1, 0, 87, 0);
    tick();
    check("basic_ready_back", int'(irdy[0]), 1);
    check("basic_valid_drop", int'(ov[0]), 0);
    ordy[0] = 1'b0;

    // Overflow, ACC_W=6
    ordy[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin iv[1] = 1'b1; id[1] = 5'b11111; tick(); end
    iv[1] = 1'b0;
    lit("ovf", 1, 1, 0, 60, 1);
    tick();
    for (int i = 0; i < 4; i++) begin iv[1] = 1'b1; id[1] = 5'b00001; tick(); end
    iv[1] = 1'b0;
    lit("ovf_clear", 1, 1, 0, 4, 0);
    tick();
    ordy[1] = 1'b0;

    // Output backpressure
    for (int i = 0; i < 4; i++) begin iv[0] = 1'b1; id[0] = 5'b00101; tick(); end
    id[0] = 5'b00011;
    for (int i = 0; i < 5; i++) begin
      lit("bp_hold", 0, 1, 0, 20, 0);
      tick();
    end
    ordy[0] = 1'b1;
    tick();
    check("bp_released", int'(irdy[0]), 1);
    for (int i = 0; i < 4; i++) tick();
    iv[0] = 1'b0;
    lit("bp_after", 0, 1, 0, 12, 0);
    tick();

    // Input gaps
    for (int i = 0; i < 7; i++) begin
      iv[0] = gap_pat[i]; id[0] = 5'b00010;
      tick();
      if (i < 6) check("gap_no_early_valid", int'(ov[0]), 0);
    end
    iv[0] = 1'b0;
    lit("gap", 0, 1, 0, 8, 0);
    tick();

    // Reset mid-operation
    for (int i = 0; i < 2; i++) begin iv[0] = 1'b1; id[0] = 5'b11111; tick(); end
    iv[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lit("rst_mid", 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin iv[0] = 1'b1; id[0] = 5'b00001; tick(); end
    iv[0] = 1'b0;
    lit("rst_after", 0, 1, 0, 4, 0);
    tick();

    // BEATS=1
    ordy[2] = 1'b1;
    iv[2] = 1'b1; id[2] = 5'b00111;
    tick();
    id[2] = 5'b01000;
    lit("b1_first", 2, 1, 0, 7, 0);
    tick();
    check("b1_gap_ready", int'(irdy[2]), 1);
    check("b1_gap_valid", int'(ov[2]), 0);
    tick();
    iv[2] = 1'b0;
    lit("b1_second", 2, 1, 0, 8, 0);
    tick();
    check("b1_idle_valid", int'(ov[2]), 0);

    idle_all();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
